sobel_control_unit: RTL and testbench

- Sobel edge-detection controller for a grayscale frame held in an external synchronous RAM.
- For every output pixel in raster order it fetches the 3x3 neighbourhood by address and computes |Gx|+|Gy| saturated to 8 bits.
- Emits the result with a one-cycle completion strobe.
- Sits between the frame buffer (read port) and the downstream output writer.

---
 rtl/sobel_control_unit.sv | 186 ++++++++++++++++++
 tb/tb_sobel_control_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_control_unit.sv
// Sobel edge-detection controller: walks the frame in raster order, fetches each
// 3x3 neighbourhood from an external synchronous RAM and emits |Gx|+|Gy|
// saturated to the pixel width, with a one-cycle completion strobe.
module sobel_control_unit #(
    parameter int unsigned PIXEL_WIDTH = 8,
    parameter int unsigned IMG_WIDTH   = 320,
    parameter int unsigned IMG_HEIGHT  = 240,
    parameter int unsigned ADDR_BITS   = 17
) (
    input  logic                   sobel_clk_i,
    input  logic                   nreset_i,
    input  logic                   prep_allowed_i,
    input  logic [PIXEL_WIDTH-1:0] input_px_gray_i,
    output logic [ADDR_BITS-1:0]   read_addr_o,
    output logic [PIXEL_WIDTH-1:0] output_px_sobel_o,
    output logic                   pixel_completed_o
);

    localparam int unsigned COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned LAST_STEP = 9;
    localparam int unsigned LAST_ADDR_STEP = 8;
    localparam int unsigned ACC_W     = PIXEL_WIDTH + 4;
    localparam int unsigned PX_MAX    = (2 ** PIXEL_WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE
    } state_t;

    state_t                   state;
    logic [STEP_W-1:0]        step;
    logic [ROW_W-1:0]         row;
    logic [COL_W-1:0]         col;
    logic [PIXEL_WIDTH-1:0]   win [0:7];

    logic                     col_last;
    logic                     frame_last;
    logic [COL_W-1:0]         nxt_col;
    logic [ROW_W-1:0]         nxt_row;

    logic [ROW_W-1:0]         tgt_row;
    logic [COL_W-1:0]         tgt_col;
    logic [STEP_W-1:0]        tgt_k;
    logic [1:0]               kr;
    logic [1:0]               kc;
    logic [ROW_W-1:0]         nb_row;
    logic [COL_W-1:0]         nb_col;
    logic [ADDR_BITS-1:0]     nb_addr;

    logic signed [ACC_W-1:0]  n [0:8];
    logic signed [ACC_W-1:0]  gx;
    logic signed [ACC_W-1:0]  gy;
    logic [ACC_W-1:0]         ax;
    logic [ACC_W-1:0]         ay;
    logic [ACC_W-1:0]         mag;
    logic [PIXEL_WIDTH-1:0]   sat;

    // Raster position of the pixel that follows the current one
    always_comb begin
        col_last   = (col == COL_W'(IMG_WIDTH - 1));
        frame_last = col_last && (row == ROW_W'(IMG_HEIGHT - 1));
        nxt_col    = col_last ? '0 : col + 1'b1;
        nxt_row    = col_last ? row + 1'b1 : row;
    end

    // Address of the neighbour to present on the next cycle, with edge clamping
    always_comb begin
        tgt_row = row;
        tgt_col = col;
        tgt_k   = '0;
        if (state == FETCH) begin
            if (step == STEP_W'(LAST_STEP)) begin
                tgt_row = nxt_row;
                tgt_col = nxt_col;
            end else begin
                tgt_k = step + 1'b1;
            end
        end

        if (tgt_k < STEP_W'(3)) begin
            kr = 2'd0;
            kc = tgt_k[1:0];
        end else if (tgt_k < STEP_W'(6)) begin
            kr = 2'd1;
            kc = 2'(tgt_k - STEP_W'(3));
        end else begin
            kr = 2'd2;
            kc = 2'(tgt_k - STEP_W'(6));
        end

        nb_row = tgt_row;
        if (kr == 2'd0 && tgt_row != '0) begin
            nb_row = tgt_row - 1'b1;
        end else if (kr == 2'd2 && tgt_row != ROW_W'(IMG_HEIGHT - 1)) begin
            nb_row = tgt_row + 1'b1;
        end

        nb_col = tgt_col;
        if (kc == 2'd0 && tgt_col != '0) begin
            nb_col = tgt_col - 1'b1;
        end else if (kc == 2'd2 && tgt_col != COL_W'(IMG_WIDTH - 1)) begin
            nb_col = tgt_col + 1'b1;
        end

        nb_addr = ADDR_BITS'(nb_row) * ADDR_BITS'(IMG_WIDTH) + ADDR_BITS'(nb_col);
    end

    // Sobel magnitude; the last neighbour comes straight from the RAM data bus
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            n[i] = ACC_W'(win[i]);
        end
        n[8] = ACC_W'(input_px_gray_i);
        gx   = (n[2] + (n[5] <<< 1) + n[8]) - (n[0] + (n[3] <<< 1) + n[6]);
        gy   = (n[6] + (n[7] <<< 1) + n[8]) - (n[0] + (n[1] <<< 1) + n[2]);
        ax   = gx[ACC_W-1] ? -gx : gx;
        ay   = gy[ACC_W-1] ? -gy : gy;
        mag  = ax + ay;
        sat  = (mag > ACC_W'(PX_MAX)) ? PIXEL_WIDTH'(PX_MAX) : mag[PIXEL_WIDTH-1:0];
    end

    // Control FSM: sequencing, neighbourhood capture and registered outputs
    always_ff @(posedge sobel_clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state             <= IDLE;
            step              <= '0;
            row               <= '0;
            col               <= '0;
            read_addr_o       <= '0;
            output_px_sobel_o <= '0;
            pixel_completed_o <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                win[i] <= '0;
            end
        end else begin
            pixel_completed_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (prep_allowed_i) begin
                        state       <= FETCH;
                        step        <= '0;
                        read_addr_o <= nb_addr;
                    end else begin
                        read_addr_o <= '0;
                    end
                end
                FETCH: begin
                    if (step != '0 && step != STEP_W'(LAST_STEP)) begin
                        win[3'(step - 1'b1)] <= input_px_gray_i;
                    end
                    if (step == '0 && !prep_allowed_i) begin
                        state       <= IDLE;
                        read_addr_o <= '0;
                    end else if (step == STEP_W'(LAST_STEP)) begin
                        output_px_sobel_o <= sat;
                        pixel_completed_o <= 1'b1;
                        step              <= '0;
                        if (frame_last) begin
                            state       <= DONE;
                            read_addr_o <= '0;
                        end else begin
                            row         <= nxt_row;
                            col         <= nxt_col;
                            read_addr_o <= nb_addr;
                        end
                    end else begin
                        step <= step + 1'b1;
                        if (step != STEP_W'(LAST_ADDR_STEP)) begin
                            read_addr_o <= nb_addr;
                        end
                    end
                end
                DONE: begin
                    read_addr_o <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_control_unit.sv
// Bench for sobel_control_unit: a small-frame instance checked cycle by cycle
// against an integer Sobel model, plus a full-size instance for the first pixel.
module tb_sobel_control_unit;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int AB = 6;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic          prep;
    logic [PW-1:0] rdata;
    logic [AB-1:0] addr;
    logic [PW-1:0] pxout;
    logic          pulse;

    logic          nreset_b;
    logic          prep_b;
    logic [7:0]    rdata_b = 8'd0;
    logic [16:0]   addr_b;
    logic [7:0]    out_b;
    logic          pulse_b;

    logic [PW-1:0] mem [W*H];

    int  checks = 0;
    int  errors = 0;
    bit  pend   = 1'b0;
    int  pend_val = 0;
    int  last_val = 0;
    int  pulses = 0;

    always #5 clk = ~clk;

    sobel_control_unit #(
        .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_BITS(AB)
    ) dut (
        .sobel_clk_i(clk), .nreset_i(nreset), .prep_allowed_i(prep),
        .input_px_gray_i(rdata), .read_addr_o(addr),
        .output_px_sobel_o(pxout), .pixel_completed_o(pulse)
    );

    sobel_control_unit big (
        .sobel_clk_i(clk), .nreset_i(nreset_b), .prep_allowed_i(prep_b),
        .input_px_gray_i(rdata_b), .read_addr_o(addr_b),
        .output_px_sobel_o(out_b), .pixel_completed_o(pulse_b)
    );

    // Synchronous frame-buffer RAM
    always @(posedge clk) rdata <= mem[addr];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nb_addr(input int r, input int c, input int k,
                                   input int w, input int h);
        int rr = r + k / 3 - 1;
        int cc = c + k % 3 - 1;
        if (rr < 0) rr = 0;
        if (rr > h - 1) rr = h - 1;
        if (cc < 0) cc = 0;
        if (cc > w - 1) cc = w - 1;
        return rr * w + cc;
    endfunction

    function automatic int ref_pix(input int r, input int c);
        int v[9];
        int gx, gy, s;
        for (int k = 0; k < 9; k++) v[k] = int'(mem[nb_addr(r, c, k, W, H)]);
        gx = (v[2] + 2 * v[5] + v[8]) - (v[0] + 2 * v[3] + v[6]);
        gy = (v[6] + 2 * v[7] + v[8]) - (v[0] + 2 * v[1] + v[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        s = gx + gy;
        return (s > 255) ? 255 : s;
    endfunction

    // One sampled cycle: address (if defined), strobe, and result/hold value
    task automatic cycle_check(input int exp_addr);
        if (exp_addr >= 0) check("addr", int'(addr), exp_addr);
        check("pulse", int'(pulse), int'(pend));
        if (pulse) pulses++;
        if (pend) begin
            check("result", int'(pxout), pend_val);
            last_val = pend_val;
        end else begin
            check("hold", int'(pxout), last_val);
        end
        pend = 1'b0;
    endtask

    task automatic step_pixel(input int p, input int kmax, input bit rnd);
        int r = p / W;
        int c = p % W;
        int n;
        for (int k = 0; k <= kmax; k++) begin
            cycle_check((k <= 8) ? nb_addr(r, c, k, W, H) : -1);
            if (k == 0 && rnd && $urandom_range(0, 3) == 0) begin
                prep = 1'b0;
                @(negedge clk);
                n = int'($urandom_range(1, 4));
                for (int i = 0; i < n; i++) begin
                    cycle_check(0);
                    if (i == n - 1) prep = 1'b1;
                    @(negedge clk);
                end
                cycle_check(nb_addr(r, c, 0, W, H));
            end
            if (k == 0) prep = 1'b1;
            else if (rnd) prep = 1'($urandom_range(0, 1));
            if (k == 9) begin
                pend     = 1'b1;
                pend_val = ref_pix(r, c);
            end
            @(negedge clk);
        end
    endtask

    task automatic done_check(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_check(0);
            prep = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input bit rnd);
        pulses = 0;
        for (int p = 0; p < W * H; p++) step_pixel(p, 9, rnd);
        done_check(20);
        check("pulse_count", pulses, W * H);
    endtask

    // Called at a negedge: assert reset and check the immediate reset values
    task automatic apply_reset();
        nreset = 1'b0;
        prep   = 1'b0;
        #1;
        check("rst_addr", int'(addr), 0);
        check("rst_out", int'(pxout), 0);
        check("rst_pulse", int'(pulse), 0);
        pend     = 1'b0;
        last_val = 0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_start();
        nreset = 1'b1;
        prep   = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * H; i++) mem[i] = PW'($urandom);
    endtask

    task automatic fill_vstep(input int a, input int b);
        for (int i = 0; i < W * H; i++) mem[i] = PW'(((i % W) < W / 2) ? a : b);
    endtask

    initial begin
        nreset   = 1'b0;
        prep     = 1'b0;
        nreset_b = 1'b0;
        prep_b   = 1'b0;
        fill_random();
        #1;
        check("big_rst_addr", int'(addr_b), 0);
        check("big_rst_out", int'(out_b), 0);
        check("big_rst_pulse", int'(pulse_b), 0);

        // Full-size instance: first pixel address sequence and strobe latency
        @(negedge clk);
        nreset_b = 1'b1;
        prep_b   = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc <= 8) check("big_addr", int'(addr_b), nb_addr(0, 0, cyc, 320, 240));
            check("big_pulse", int'(pulse_b), (cyc == 10) ? 1 : 0);
            @(negedge clk);
        end
        check("big_out", int'(out_b), 0);
        nreset_b = 1'b0;

        // Random frame, enable held high
        apply_reset();
        release_start();
        run_frame(1'b0);

        // Uniform frame
        apply_reset();
        for (int i = 0; i < W * H; i++) mem[i] = PW'(8'h80);
        release_start();
        run_frame(1'b1);

        // Vertical step 10 | 20
        apply_reset();
        fill_vstep(10, 20);
        release_start();
        run_frame(1'b1);

        // Vertical step 0 | 255 with enable held low for 50 cycles first
        apply_reset();
        fill_vstep(0, 255);
        nreset = 1'b1;
        prep   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cycle_check(0);
        end
        prep = 1'b1;
        @(negedge clk);
        run_frame(1'b1);

        // Reset at step 5 of pixel 3, then a full frame
        apply_reset();
        fill_random();
        release_start();
        for (int p = 0; p < 3; p++) step_pixel(p, 9, 1'b0);
        step_pixel(3, 4, 1'b0);
        apply_reset();
        release_start();
        run_frame(1'b1);

        // One more random frame with random enable gaps
        apply_reset();
        fill_random();
        release_start();
        run_frame(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
